// File: rtl/shoelace_handshake_seq.sv
// Shoelace handshake sequencer: settles every channel req at INIT, then walks a four-phase
// req/ack handshake through channels 0..NCH-1 with a bounded wait in each phase.
module shoelace_handshake_seq #(
    parameter int             NCH         = 4,
    parameter int             CH_W        = 2,
    parameter logic [NCH-1:0] INIT        = 4'b0100,
    parameter int             HOLD_CYCLES = 5,
    parameter int             TIMEOUT     = 16,
    parameter int             CNT_W       = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [NCH-1:0]   ack,
    output logic [NCH-1:0]   req,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CH_W-1:0]  err_chan,
    output logic [CNT_W-1:0] round_cycles
);
    // state   | meaning
    // IDLE    | out of reset, waiting for start
    // HOLD    | all reqs driven to INIT while the netlist settles
    // CLEAR   | all reqs low for one cycle, channel index reset
    // RAISE   | waiting for ack[idx] low before raising req[idx]
    // WAIT_UP | req[idx] high, waiting for ack[idx] high
    // LOWER   | dropping req[idx]
    // WAIT_DN | waiting for ack[idx] low, then next channel or DONE
    // DONE    | round finished, results held
    // ERR     | a phase timed out, err_chan holds the channel

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, HOLD, CLEAR, RAISE, WAIT_UP, LOWER, WAIT_DN, DONE, ERR
    } state_t;

    state_t          state;
    logic [CH_W-1:0] idx;
    logic [HC_W-1:0] hold_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [NCH-1:0]  chan_mask;
    logic            ack_sel;
    logic            to_last;
    logic            last_chan;
    logic            in_round;
    logic            phase_wait;
    logic            phase_exit;

    assign chan_mask  = NCH'(1) << idx;
    assign ack_sel    = |(ack & chan_mask);
    assign to_last    = (to_cnt == TO_W'(TIMEOUT - 1));
    assign last_chan  = (idx == CH_W'(NCH - 1));
    assign in_round   = (state != IDLE) && (state != DONE) && (state != ERR);
    assign phase_wait = (state == RAISE) || (state == WAIT_UP) || (state == WAIT_DN);
    // WAIT_UP leaves on ack high; RAISE and WAIT_DN both leave on ack low
    assign phase_exit = (state == WAIT_UP) ? ack_sel : !ack_sel;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            req          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            err_chan     <= '0;
            round_cycles <= '0;
            idx          <= '0;
            hold_cnt     <= '0;
            to_cnt       <= '0;
        end else begin
            if (in_round && (round_cycles != '1)) begin
                round_cycles <= round_cycles + CNT_W'(1);
            end
            if (phase_wait && !phase_exit) begin
                if (to_last) begin
                    state       <= ERR;
                    req         <= '0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                    err_chan    <= idx;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (start) begin
                            state        <= HOLD;
                            req          <= INIT;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            timeout_err  <= 1'b0;
                            err_chan     <= '0;
                            round_cycles <= '0;
                            hold_cnt     <= HC_W'(HOLD_CYCLES - 1);
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state <= CLEAR;
                            req   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - HC_W'(1);
                        end
                    end
                    CLEAR: begin
                        idx    <= '0;
                        to_cnt <= '0;
                        state  <= RAISE;
                    end
                    RAISE: begin
                        req    <= chan_mask;
                        to_cnt <= '0;
                        state  <= WAIT_UP;
                    end
                    WAIT_UP: begin
                        state <= LOWER;
                    end
                    LOWER: begin
                        req    <= '0;
                        to_cnt <= '0;
                        state  <= WAIT_DN;
                    end
                    WAIT_DN: begin
                        to_cnt <= '0;
                        if (last_chan) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + CH_W'(1);
                            state <= RAISE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shoelace_handshake_seq.sv
// Directed bench for shoelace_handshake_seq: a table of handshake rounds with hand-computed
// outcomes, plus sequences for hold window, start-while-busy, mid-round reset and NCH=1.
module tb_shoelace_handshake_seq;
    logic        clk = 1'b0;
    logic        nreset;
    logic        start, start1;
    logic [3:0]  ack, req;
    logic        busy, done, timeout_err;
    logic [1:0]  err_chan;
    logic [15:0] round_cycles;
    logic [0:0]  ack1, req1, err_chan1;
    logic        busy1, done1, terr1;
    logic [15:0] rc1;

    always #5 clk = ~clk;

    shoelace_handshake_seq dut (
        .clk(clk), .nreset(nreset), .start(start), .ack(ack), .req(req), .busy(busy),
        .done(done), .timeout_err(timeout_err), .err_chan(err_chan), .round_cycles(round_cycles)
    );

    shoelace_handshake_seq #(
        .NCH(1), .CH_W(1), .INIT(1'b1), .HOLD_CYCLES(1), .TIMEOUT(16), .CNT_W(16)
    ) dut1 (
        .clk(clk), .nreset(nreset), .start(start1), .ack(ack1), .req(req1), .busy(busy1),
        .done(done1), .timeout_err(terr1), .err_chan(err_chan1), .round_cycles(rc1)
    );

    typedef struct {
        string      name;
        logic [3:0] lo;
        logic [3:0] hi;
        int         hi_until;
        logic       exp_done;
        logic       exp_terr;
        logic [1:0] exp_chan;
        int         exp_rc;
    } vec_t;

    vec_t       vecs[9];
    int         applied = 0;
    int         errors  = 0;
    int         cyc = 0;
    int         hi_until = 0;
    int         glitch_at = 0;
    int         a1_on = 0;
    int         a1_off = 0;
    logic [3:0] lo_mask = 4'b0000;
    logic [3:0] hi_mask = 4'b0000;
    logic [3:0] req_d = 4'b0000;

    function automatic vec_t mk(input string n, input logic [3:0] lo, input logic [3:0] hi,
                                input int hu, input logic d, input logic t,
                                input logic [1:0] ch, input int rc);
        vec_t v;
        v.name = n; v.lo = lo; v.hi = hi; v.hi_until = hu;
        v.exp_done = d; v.exp_terr = t; v.exp_chan = ch; v.exp_rc = rc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // one cycle of the netlist model: ack echoes req one cycle late, with stuck overrides
    task automatic tick();
        @(negedge clk);
        cyc++;
        ack   = (req_d & ~lo_mask) | ((cyc < hi_until) ? hi_mask : 4'b0000);
        req_d = req;
        ack1  = ((cyc >= a1_on) && (cyc < a1_off)) ? 1'b1 : 1'b0;
        if (glitch_at != 0) start = (cyc == glitch_at);
    endtask

    task automatic start_round(input bit which);
        tick();
        if (which) start1 = 1'b1;
        else       start  = 1'b1;
        cyc = 0;
        tick();
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_end(input bit which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = which ? (done1 | terr1) : (done | timeout_err);
        end
        if (!seen) begin
            applied++;
            errors++;
            $display("FAIL %s: round did not reach DONE or ERR within 300 cycles", name);
        end
    endtask

    task automatic settle();
        lo_mask = 4'b0000;
        hi_mask = 4'b0000;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  prev;
        logic [15:0] order_seq;
        int          nrise;
        int          multi_hot;

        vecs[0] = mk("normal",        4'b0000, 4'b0000, 0,    1'b1, 1'b0, 2'd0, 30);
        vecs[1] = mk("ack2_stuck_lo", 4'b0100, 4'b0000, 0,    1'b0, 1'b1, 2'd2, 35);
        vecs[2] = mk("ack1_stale_3",  4'b0000, 4'b0010, 16,   1'b1, 1'b0, 2'd0, 33);
        vecs[3] = mk("ack1_stale_20", 4'b0000, 4'b0010, 33,   1'b0, 1'b1, 2'd1, 28);
        vecs[4] = mk("raise_edge_ok", 4'b0000, 4'b0010, 28,   1'b1, 1'b0, 2'd0, 45);
        vecs[5] = mk("raise_edge_to", 4'b0000, 4'b0010, 29,   1'b0, 1'b1, 2'd1, 28);
        vecs[6] = mk("ack3_stuck_lo", 4'b1000, 4'b0000, 0,    1'b0, 1'b1, 2'd3, 41);
        vecs[7] = mk("ack0_stuck_hi", 4'b0000, 4'b0001, 1000, 1'b0, 1'b1, 2'd0, 22);
        vecs[8] = mk("ack0_stuck_lo", 4'b0001, 4'b0000, 0,    1'b0, 1'b1, 2'd0, 23);

        nreset = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        ack    = 4'b0000;
        ack1   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst req",          32'(req),          32'(4'b0000));
        check("rst busy",         32'(busy),         32'(1'b0));
        check("rst done",         32'(done),         32'(1'b0));
        check("rst timeout_err",  32'(timeout_err),  32'(1'b0));
        check("rst err_chan",     32'(err_chan),     32'(2'd0));
        check("rst round_cycles", 32'(round_cycles), 32'(16'd0));
        check("rst nch1 req",     32'(req1),         32'(1'b0));
        nreset = 1'b1;
        settle();

        // hold window, channel order and one-hot req
        start_round(0);
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("hold req c%0d", k), 32'(req), 32'(4'b0100));
            check($sformatf("hold busy c%0d", k), 32'(busy), 32'(1'b1));
            tick();
        end
        check("clear req", 32'(req), 32'(4'b0000));
        prev = req; order_seq = 16'h0; nrise = 0; multi_hot = 0;
        for (int i = 0; i < 200 && !done && !timeout_err; i++) begin
            tick();
            if ($countones(req) > 1) multi_hot++;
            for (int c = 0; c < 4; c++) begin
                if (req[c] && !prev[c]) begin
                    order_seq = {order_seq[11:0], 4'(c)};
                    nrise++;
                end
            end
            prev = req;
        end
        check("order req rises",  32'(nrise),        32'(4));
        check("order channels",   32'(order_seq),    32'(16'h0123));
        check("order one-hot",    32'(multi_hot),    32'(0));
        check("order done",       32'(done),         32'(1'b1));
        check("order rc",         32'(round_cycles), 32'(30));
        repeat (4) tick();
        check("held done",        32'(done),         32'(1'b1));
        check("frozen rc",        32'(round_cycles), 32'(30));
        check("held req",         32'(req),          32'(4'b0000));
        settle();

        foreach (vecs[i]) begin
            lo_mask  = vecs[i].lo;
            hi_mask  = vecs[i].hi;
            hi_until = vecs[i].hi_until;
            start_round(0);
            wait_end(0, vecs[i].name);
            check({vecs[i].name, " done"},        32'(done),         32'(vecs[i].exp_done));
            check({vecs[i].name, " timeout_err"}, 32'(timeout_err),  32'(vecs[i].exp_terr));
            check({vecs[i].name, " err_chan"},    32'(err_chan),     32'(vecs[i].exp_chan));
            check({vecs[i].name, " round_cycles"}, 32'(round_cycles), 32'(vecs[i].exp_rc));
            check({vecs[i].name, " req"},         32'(req),          32'(4'b0000));
            check({vecs[i].name, " busy"},        32'(busy),         32'(1'b0));
            settle();
        end
        hi_until = 0;

        // start pulsed during WAIT_UP on channel 1 must be ignored
        glitch_at = 14;
        start_round(0);
        wait_end(0, "start_busy");
        glitch_at = 0;
        start     = 1'b0;
        check("start_busy done", 32'(done),         32'(1'b1));
        check("start_busy terr", 32'(timeout_err),  32'(1'b0));
        check("start_busy rc",   32'(round_cycles), 32'(30));
        settle();

        // reset while req[2] is high, then replay
        start_round(0);
        while (cyc < 20) tick();
        check("pre-reset req", 32'(req),  32'(4'b0100));
        check("pre-reset busy", 32'(busy), 32'(1'b1));
        nreset = 1'b0;
        #1;
        check("async reset req",  32'(req),          32'(4'b0000));
        check("async reset busy", 32'(busy),         32'(1'b0));
        check("async reset rc",   32'(round_cycles), 32'(0));
        @(negedge clk);
        nreset = 1'b1;
        settle();
        start_round(0);
        check("replay req", 32'(req),  32'(4'b0100));
        check("replay busy", 32'(busy), 32'(1'b1));
        wait_end(0, "replay");
        check("replay done", 32'(done),         32'(1'b1));
        check("replay rc",   32'(round_cycles), 32'(30));
        settle();

        // NCH=1: ack arrives on the last allowed WAIT_UP cycle -> exit wins
        a1_on = 19; a1_off = 21;
        start_round(1);
        check("nch1 hold req", 32'(req1), 32'(1'b1));
        check("nch1 busy",     32'(busy1), 32'(1'b1));
        tick();
        check("nch1 clear req", 32'(req1), 32'(1'b0));
        tick();
        tick();
        check("nch1 wait_up req", 32'(req1), 32'(1'b1));
        wait_end(1, "nch1_edge_ok");
        check("nch1_edge_ok done", 32'(done1), 32'(1'b1));
        check("nch1_edge_ok terr", 32'(terr1), 32'(1'b0));
        check("nch1_edge_ok rc",   32'(rc1),   32'(21));
        settle();

        // one cycle later -> timeout
        a1_on = 20; a1_off = 22;
        start_round(1);
        wait_end(1, "nch1_edge_to");
        check("nch1_edge_to done", 32'(done1),     32'(1'b0));
        check("nch1_edge_to terr", 32'(terr1),     32'(1'b1));
        check("nch1_edge_to chan", 32'(err_chan1), 32'(1'b0));
        check("nch1_edge_to req",  32'(req1),      32'(1'b0));
        check("nch1_edge_to rc",   32'(rc1),       32'(19));
        a1_on = 0; a1_off = 0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
